mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequential arbiter that lets the pipelined datapath's fetch stage and memory stage share one single-port, variable-latency unified memory.
- Sits between the datapath's IM/DM ports and the memory.
- Serialises fetch and data requests with a req/done handshake and drives a pipeline stall.
- Data accesses have priority; a streak limit bounds fetch starvation, and a watchdog aborts hung accesses.

Parameters:
- N, 64, address/data width
- IW, 32, instruction width (fetch data = mem_rdata[IW-1:0])
- STREAK, 4, max consecutive data grants while a fetch is pending
- TIMEOUT, 15, max BUSY cycles without mem_ack before abort

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  N  fetch address
- if_rdata  out  IW  fetched instruction, valid with if_done and held afterwards
- if_done  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  N  data address
- dm_wdata  in  N  write data
- dm_rdata  out  N  read data, valid with dm_done and held afterwards
- dm_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  memory write strobe
- mem_addr  out  N  memory address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- stall  out  1  pipeline stall
- busy  out  1  high in BUSY_F/BUSY_D
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: reset==0 at posedge puts the FSM in IDLE and clears all registered outputs, mem_* outputs, if_rdata, dm_rdata, the streak counter, the wait counter and timeout_err. stall is forced to 0 while reset==0.
- FSM states: IDLE, BUSY_F, BUSY_D.
- IDLE arbitration, in priority order:
  - dm_req and (streak<STREAK or not if_req): grant D.
  - else if_req: grant F.
  - else stay in IDLE.
- Done suppression: in a cycle where if_done (dm_done) is high, if_req (dm_req) is treated as 0.
- On a grant:
  - Latch address, we and wdata into the mem_* registers; mem_req=1 from the next cycle.
  - For F, mem_we=0.
  - Wait counter := 0.
- Requester inputs are ignored after the grant edge. A requester dropping its req mid-transaction does not cancel the access, and its done pulse is still issued.
- BUSY_x with mem_ack=1:
  - Next cycle: mem_req=0, mem_we=0, FSM in IDLE, done pulse for x.
  - On a read, capture if_rdata=mem_rdata[IW-1:0] or dm_rdata=mem_rdata.
  - On a write, dm_rdata is unchanged.
- BUSY_x without ack: the wait counter increments.
  - Wait counter reaches TIMEOUT: abort. Next cycle mem_req=0, FSM in IDLE, done pulse for x, read data captured as 0, timeout_err=1.
  - timeout_err stays set until reset.
- mem_ack in IDLE is ignored.
- Latency: with zero-wait memory, the grant edge is at the end of the req cycle, ack arrives in the first mem_req cycle, and done is 2 cycles after req. There is at least one IDLE cycle between transactions.
- Streak counter (saturates at STREAK):
  - D grant with if_req high: streak+1.
  - D grant with if_req low, or any F grant: streak := 0.
- stall = (if_req & ~if_done) | (dm_req & ~dm_done). This is combinational on registered done and the inputs.
- busy is high in the BUSY states.
- Simultaneous events: if mem_ack and the timeout occur in the same cycle, the ack wins and no error is raised.
- Reset in mid-transaction: mem_req drops on the next edge, no done pulse is issued, and the pending access is discarded.

Test Plan:
1. Zero-wait fetch: if_req=1, if_addr=0x40, mem_ack in the first mem_req cycle with mem_rdata=0x8B020020 -> mem_addr=0x40; if_done pulses 2 cycles after req; if_rdata=0x8B020020; stall=0 in the done cycle.
2. Write with 3 wait cycles: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEAD -> mem_we=1 and mem_wdata=0xDEAD held 4 cycles; dm_done pulses once; dm_rdata unchanged.
3. Contention and streak: if_req and dm_req held continuously, STREAK=4, zero-wait memory -> grant order D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each F.
4. Timeout: dm_req read, mem_ack never asserted -> after 15 BUSY cycles, dm_done pulses with dm_rdata=0, timeout_err=1 and stays 1. A subsequent fetch still completes normally.
5. Reset mid-access: reset=0 during BUSY_D -> next cycle all outputs 0, FSM in IDLE, no dm_done. After release, a new request is granted normally.
6. Done suppression: requester keeps req high in the done cycle, then drops it -> no duplicate grant and no second mem_req.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets the fetch stage (IM port) and the memory stage (DM port) of a
// pipelined datapath share one single-port, variable-latency unified memory.
// Requests are serialised with a req/done handshake. Data accesses win
// arbitration, but a streak counter bounds how long a pending fetch can be
// starved. A watchdog aborts an access the memory never acknowledges.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   if_req/if_addr    fetch request (held until if_done) and address
//   if_rdata/if_done  fetched instruction (held) and one-cycle done pulse
//   dm_req/dm_we      data request (held until dm_done), 1 = write
//   dm_addr/dm_wdata  data address and write data
//   dm_rdata/dm_done  read data (held) and one-cycle done pulse
//   mem_req/mem_we    memory request (held until ack/abort) and write strobe
//   mem_addr/wdata    memory address and write data
//   mem_rdata/ack     memory read data, valid with the one-cycle ack
//   stall             pipeline stall while any request is unserved
//   busy              high while an access is outstanding
//   timeout_err       sticky watchdog error, cleared only by reset
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N       = 64,
  parameter int IW      = 32,
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [N-1:0]  if_addr,
  output logic [IW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [N-1:0]  dm_addr,
  input  logic [N-1:0]  dm_wdata,
  output logic [N-1:0]  dm_rdata,
  output logic          dm_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          busy,
  output logic          timeout_err
);

  localparam int SW = $clog2(STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e          state_q,       state_d;
  logic            mem_req_q,     mem_req_d;
  logic            mem_we_q,      mem_we_d;
  logic [N-1:0]    mem_addr_q,    mem_addr_d;
  logic [N-1:0]    mem_wdata_q,   mem_wdata_d;
  logic [IW-1:0]   if_rdata_q,    if_rdata_d;
  logic [N-1:0]    dm_rdata_q,    dm_rdata_d;
  logic            if_done_q,     if_done_d;
  logic            dm_done_q,     dm_done_d;
  logic [SW-1:0]   streak_q,      streak_d;
  logic [WW-1:0]   wait_q,        wait_d;
  logic            timeout_err_q, timeout_err_d;

  // Effective requests: a requester still sees its own req high in the cycle
  // its done pulse is out, so that cycle's req must not start a new access.
  logic            if_req_eff;
  logic            dm_req_eff;
  logic            done_gap;
  logic            grant_d;
  logic [WW-1:0]   wait_inc;
  logic [N-1:0]    rd_word;

  assign if_req_eff = if_req & ~if_done_q;
  assign dm_req_eff = dm_req & ~dm_done_q;
  // Every done cycle is a grant-free IDLE cycle, so transactions are always
  // separated by at least one idle cycle and a waiting requester is served
  // on the cycle after a done pulse.
  assign done_gap   = if_done_q | dm_done_q;
  assign grant_d    = dm_req_eff & ((streak_q < SW'(STREAK)) | ~if_req_eff);
  assign wait_inc   = wait_q + WW'(1);

  // NOTE: every signal written here gets its default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_done_d     = 1'b0;
    dm_done_d     = 1'b0;
    streak_d      = streak_q;
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
    rd_word       = '0;

    case (state_q)
      IDLE: begin
        // mem_ack is deliberately ignored here.
        if (!done_gap) begin
          if (grant_d) begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            wait_d      = '0;
            // Only count data grants that actually made a fetch wait.
            if (if_req_eff) begin
              streak_d = (streak_q == SW'(STREAK)) ? streak_q : streak_q + SW'(1);
            end else begin
              streak_d = '0;
            end
          end else if (if_req_eff) begin
            state_d    = BUSY_F;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            wait_d     = '0;
            streak_d   = '0;
          end
        end
      end

      BUSY_F, BUSY_D: begin
        // An ack in the same cycle the watchdog expires still completes the
        // access normally: the ack is checked first.
        if (mem_ack || (wait_inc == WW'(TIMEOUT))) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wait_d    = '0;
          if (!mem_ack) begin
            timeout_err_d = 1'b1;
          end
          // An aborted read returns zero.
          rd_word = mem_ack ? mem_rdata : '0;
          if (state_q == BUSY_F) begin
            if_done_d  = 1'b1;
            if_rdata_d = rd_word[IW-1:0];
          end else begin
            dm_done_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = rd_word;
            end
          end
        end else begin
          wait_d = wait_inc;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the data registers are cleared too, so that after reset the
      // read-data outputs and memory address/data buses are known zeros
      // rather than stale values from an abandoned access.
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_done_q     <= 1'b0;
      dm_done_q     <= 1'b0;
      streak_q      <= '0;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_done_q     <= if_done_d;
      dm_done_q     <= dm_done_d;
      streak_q      <= streak_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_done     = if_done_q;
  assign dm_done     = dm_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q == BUSY_F) || (state_q == BUSY_D);

  // Stall while a request is up and its done pulse has not yet come back;
  // held low while reset is asserted.
  assign stall = reset & ((if_req & ~if_done_q) | (dm_req & ~dm_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: a cycle table for the basic
// fetch/data handshakes, hand-written sequences for waits, contention,
// timeout and reset, then randomized traffic checked against a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int N       = 64;
  localparam int IW      = 32;
  localparam int STREAK  = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [N-1:0]  if_addr;
  logic [IW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [N-1:0]  dm_addr;
  logic [N-1:0]  dm_wdata;
  logic [N-1:0]  dm_rdata;
  logic          dm_done;
  logic          mem_req;
  logic          mem_we;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
  logic          mem_ack;
  logic          stall;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N(N), .IW(IW), .STREAK(STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .busy(busy), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the active edge; outputs are sampled on the
  // falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct {
    logic          rst_n;
    logic          if_req;
    logic [N-1:0]  if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [N-1:0]  dm_addr;
    logic [N-1:0]  dm_wdata;
    logic          mem_ack;
    logic [N-1:0]  mem_rdata;
    logic          e_mem_req;
    logic          e_mem_we;
    logic [N-1:0]  e_mem_addr;
    logic          e_if_done;
    logic          e_dm_done;
    logic          e_stall;
    logic          e_busy;
    logic [IW-1:0] e_if_rdata;
    logic [N-1:0]  e_dm_rdata;
  } vec_t;

  vec_t tbl [11];

  // Reference-model state for the randomized phase.
  bit            act, act_d, act_we, act_to;
  int            g_cyc, done_cyc, lat;
  logic [N-1:0]  act_rdata;
  logic [N-1:0]  last_addr, last_wdata;
  bit            last_we;
  logic [IW-1:0] e_if_rdata;
  logic [N-1:0]  e_dm_rdata;
  bit            e_terr, e_if_done, e_dm_done, e_busy;
  int            streak;
  bit            prev_if_done, prev_dm_done;
  int            f_st, d_st;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rv;
    bit           exp_is_f [10];
    bit           got_is_f [10];
    int           cnt;

    reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // ---------------- table: zero-wait fetch / read, done-cycle hold ------
    rv = 64'hFFFF_FFFF_8B02_0020;
    //           rst if  if_addr dm we dm_addr wdata ack rdata       | mreq mwe maddr ifd dmd stl bsy if_rdata       dm_rdata
    tbl[0]  = '{0, 1, 64'h40, 0, 0, 64'h0,  64'h0, 0, 64'h0,      0, 0, 64'h0,  0, 0, 0, 0, 32'h0,        64'h0};
    tbl[1]  = '{1, 1, 64'h40, 0, 0, 64'h0,  64'h0, 0, 64'h0,      0, 0, 64'h0,  0, 0, 1, 0, 32'h0,        64'h0};
    tbl[2]  = '{1, 1, 64'h40, 0, 0, 64'h0,  64'h0, 1, rv,         1, 0, 64'h40, 0, 0, 1, 1, 32'h0,        64'h0};
    tbl[3]  = '{1, 1, 64'h40, 0, 0, 64'h0,  64'h0, 0, 64'h0,      0, 0, 64'h40, 1, 0, 0, 0, 32'h8B020020, 64'h0};
    tbl[4]  = '{1, 0, 64'h40, 0, 0, 64'h0,  64'h0, 0, 64'h0,      0, 0, 64'h40, 0, 0, 0, 0, 32'h8B020020, 64'h0};
    tbl[5]  = '{1, 0, 64'h40, 0, 0, 64'h0,  64'h0, 1, 64'h5555,   0, 0, 64'h40, 0, 0, 0, 0, 32'h8B020020, 64'h0};
    tbl[6]  = '{1, 0, 64'h40, 1, 0, 64'h88, 64'h0, 0, 64'h0,      0, 0, 64'h40, 0, 0, 1, 0, 32'h8B020020, 64'h0};
    tbl[7]  = '{1, 0, 64'h40, 1, 0, 64'h88, 64'h0, 1, 64'h1234,   1, 0, 64'h88, 0, 0, 1, 1, 32'h8B020020, 64'h0};
    tbl[8]  = '{1, 0, 64'h40, 1, 0, 64'h88, 64'h0, 0, 64'h0,      0, 0, 64'h88, 0, 1, 0, 0, 32'h8B020020, 64'h1234};
    tbl[9]  = '{1, 0, 64'h40, 0, 0, 64'h88, 64'h0, 0, 64'h0,      0, 0, 64'h88, 0, 0, 0, 0, 32'h8B020020, 64'h1234};
    tbl[10] = '{1, 0, 64'h40, 0, 0, 64'h88, 64'h0, 0, 64'h0,      0, 0, 64'h88, 0, 0, 0, 0, 32'h8B020020, 64'h1234};

    for (int i = 0; i < 11; i++) begin
      next_cycle();
      reset = tbl[i].rst_n; if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr;
      dm_wdata = tbl[i].dm_wdata; mem_ack = tbl[i].mem_ack; mem_rdata = tbl[i].mem_rdata;
      sample();
      check($sformatf("tbl%0d.mem_req", i),  mem_req,  tbl[i].e_mem_req);
      check($sformatf("tbl%0d.mem_we", i),   mem_we,   tbl[i].e_mem_we);
      check($sformatf("tbl%0d.mem_addr", i), mem_addr, tbl[i].e_mem_addr);
      check($sformatf("tbl%0d.if_done", i),  if_done,  tbl[i].e_if_done);
      check($sformatf("tbl%0d.dm_done", i),  dm_done,  tbl[i].e_dm_done);
      check($sformatf("tbl%0d.stall", i),    stall,    tbl[i].e_stall);
      check($sformatf("tbl%0d.busy", i),     busy,     tbl[i].e_busy);
      check($sformatf("tbl%0d.if_rdata", i), if_rdata, tbl[i].e_if_rdata);
      check($sformatf("tbl%0d.dm_rdata", i), dm_rdata, tbl[i].e_dm_rdata);
    end

    // ---------------- write with 3 wait cycles ---------------------------
    next_cycle();
    mem_ack = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h10; dm_wdata = 64'hDEAD;
    sample();
    check("wr.req_busy", busy, 1'b0);
    check("wr.req_stall", stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      dm_addr = 64'h99; dm_wdata = 64'hBEEF;      // ignored after the grant
      mem_ack = (k == 3); mem_rdata = 64'hBAD;
      sample();
      check($sformatf("wr.b%0d.mem_req", k),   mem_req,   1'b1);
      check($sformatf("wr.b%0d.mem_we", k),    mem_we,    1'b1);
      check($sformatf("wr.b%0d.mem_wdata", k), mem_wdata, 64'hDEAD);
      check($sformatf("wr.b%0d.mem_addr", k),  mem_addr,  64'h10);
      check($sformatf("wr.b%0d.dm_done", k),   dm_done,   1'b0);
    end
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("wr.done", dm_done, 1'b1);
    check("wr.done_mem_we", mem_we, 1'b0);
    check("wr.done_mem_req", mem_req, 1'b0);
    check("wr.dm_rdata_kept", dm_rdata, 64'h1234);
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0;
    sample();
    check("wr.single_pulse", dm_done, 1'b0);
    check("wr.idle", busy, 1'b0);

    // ---------------- ack in the last allowed cycle wins ------------------
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300;
    sample();
    for (int k = 1; k <= TIMEOUT; k++) begin
      next_cycle();
      mem_ack = (k == TIMEOUT); mem_rdata = 64'h77;
      sample();
      check($sformatf("lim.b%0d.busy", k), busy, 1'b1);
      check($sformatf("lim.b%0d.dm_done", k), dm_done, 1'b0);
    end
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("lim.done", dm_done, 1'b1);
    check("lim.rdata", dm_rdata, 64'h77);
    check("lim.no_err", timeout_err, 1'b0);
    next_cycle();
    dm_req = 1'b0;
    sample();

    // ---------------- watchdog timeout -----------------------------------
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h308;
    sample();
    for (int k = 1; k <= TIMEOUT; k++) begin
      next_cycle();
      mem_ack = 1'b0;
      sample();
      check($sformatf("to.b%0d.busy", k), busy, 1'b1);
      check($sformatf("to.b%0d.err", k), timeout_err, 1'b0);
    end
    next_cycle();
    sample();
    check("to.done", dm_done, 1'b1);
    check("to.rdata_zero", dm_rdata, 64'h0);
    check("to.err_set", timeout_err, 1'b1);
    check("to.mem_req_low", mem_req, 1'b0);
    next_cycle();
    dm_req = 1'b0;
    sample();
    check("to.err_sticky", timeout_err, 1'b1);
    next_cycle();
    if_req = 1'b1; if_addr = 64'h44;
    sample();
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'hCAFE;
    sample();
    check("to.fetch_addr", mem_addr, 64'h44);
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("to.fetch_done", if_done, 1'b1);
    check("to.fetch_rdata", if_rdata, 32'hCAFE);
    check("to.err_still", timeout_err, 1'b1);
    next_cycle();
    if_req = 1'b0;
    sample();

    // ---------------- contention and streak limit ------------------------
    exp_is_f = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    cnt = 0;
    next_cycle();
    if_req = 1'b1; if_addr = 64'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
    sample();
    for (int t = 0; t < 100 && cnt < 10; t++) begin
      next_cycle();
      mem_ack = mem_req; mem_rdata = 64'h0;   // zero-wait memory
      sample();
      if (if_done && cnt < 10) begin got_is_f[cnt] = 1'b1; cnt++; end
      if (dm_done && cnt < 10) begin got_is_f[cnt] = 1'b0; cnt++; end
    end
    check("cont.count", cnt, 10);
    for (int i = 0; i < cnt; i++) check($sformatf("cont.grant%0d_is_fetch", i), got_is_f[i], exp_is_f[i]);
    next_cycle();
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    sample();

    // ---------------- reset in the middle of a data access ----------------
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h500; dm_wdata = 64'h5;
    sample();
    next_cycle();
    sample();
    check("rst.busy_before", busy, 1'b1);
    check("rst.we_before", mem_we, 1'b1);
    next_cycle();
    reset = 1'b0;
    sample();
    check("rst.stall_forced_low", stall, 1'b0);
    next_cycle();
    reset = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    sample();
    check("rst.mem_req", mem_req, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, 64'h0);
    check("rst.mem_wdata", mem_wdata, 64'h0);
    check("rst.busy", busy, 1'b0);
    check("rst.no_done", dm_done, 1'b0);
    check("rst.if_rdata", if_rdata, 32'h0);
    check("rst.dm_rdata", dm_rdata, 64'h0);
    check("rst.err_cleared", timeout_err, 1'b0);
    next_cycle();
    sample();
    check("rst.still_no_done", dm_done, 1'b0);
    next_cycle();
    if_req = 1'b1; if_addr = 64'h60;
    sample();
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'hABC;
    sample();
    check("rst.new_grant_busy", busy, 1'b1);
    check("rst.new_grant_addr", mem_addr, 64'h60);
    next_cycle();
    mem_ack = 1'b0;
    sample();
    check("rst.new_done", if_done, 1'b1);
    check("rst.new_rdata", if_rdata, 32'hABC);
    next_cycle();
    if_req = 1'b0;
    sample();

    // ---------------- randomized traffic vs. transaction model ------------
    next_cycle();
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    sample();
    act = 0; act_d = 0; act_we = 0; act_to = 0; g_cyc = 0; done_cyc = 0; lat = 0;
    act_rdata = '0; last_addr = '0; last_wdata = '0; last_we = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_terr = 0; streak = 0;
    prev_if_done = 0; prev_dm_done = 0; f_st = 0; d_st = 0;

    for (int c = 0; c < 600; c++) begin
      next_cycle();
      reset = 1'b1;

      // Requesters: raise at random, hold until done, sometimes drop early
      // once the access is in flight.
      if (prev_if_done) f_st = 0;
      if (f_st == 0) begin
        if_req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          f_st = 1; if_req = 1'b1; if_addr = {$urandom, $urandom};
        end
      end else if (f_st == 1 && act && !act_d && $urandom_range(0, 7) == 0) begin
        f_st = 2; if_req = 1'b0;
      end
      if (prev_dm_done) d_st = 0;
      if (d_st == 0) begin
        dm_req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          d_st = 1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
        end
      end else if (d_st == 1 && act && act_d && $urandom_range(0, 7) == 0) begin
        d_st = 2; dm_req = 1'b0;
      end

      // Memory: ack once after the chosen latency; random acks while idle.
      mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
      if (act && c > g_cyc && c < done_cyc) begin
        if (lat < TIMEOUT && c == g_cyc + 1 + lat) begin
          mem_ack = 1'b1; mem_rdata = act_rdata;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end

      sample();

      e_if_done = 0; e_dm_done = 0;
      if (act && c == done_cyc) begin
        if (act_d) begin
          e_dm_done = 1;
          if (!act_we) e_dm_rdata = act_to ? '0 : act_rdata;
        end else begin
          e_if_done = 1;
          e_if_rdata = act_to ? '0 : act_rdata[IW-1:0];
        end
        if (act_to) e_terr = 1;
        act = 0;
      end
      e_busy = act && (c > g_cyc);

      check($sformatf("rnd%0d.mem_req", c),   mem_req,     e_busy);
      check($sformatf("rnd%0d.busy", c),      busy,        e_busy);
      check($sformatf("rnd%0d.mem_we", c),    mem_we,      e_busy & last_we);
      check($sformatf("rnd%0d.mem_addr", c),  mem_addr,    last_addr);
      check($sformatf("rnd%0d.mem_wdata", c), mem_wdata,   last_wdata);
      check($sformatf("rnd%0d.if_done", c),   if_done,     e_if_done);
      check($sformatf("rnd%0d.dm_done", c),   dm_done,     e_dm_done);
      check($sformatf("rnd%0d.if_rdata", c),  if_rdata,    e_if_rdata);
      check($sformatf("rnd%0d.dm_rdata", c),  dm_rdata,    e_dm_rdata);
      check($sformatf("rnd%0d.timeout", c),   timeout_err, e_terr);
      check($sformatf("rnd%0d.stall", c),     stall,
            (if_req & !e_if_done) | (dm_req & !e_dm_done));

      // Arbitration decided by this cycle's requests.
      if (!act && !e_if_done && !e_dm_done) begin
        if (dm_req && (streak < STREAK || !if_req)) begin
          act = 1; act_d = 1; act_we = dm_we;
          last_addr = dm_addr; last_we = dm_we; last_wdata = dm_wdata;
          streak = if_req ? ((streak < STREAK) ? streak + 1 : STREAK) : 0;
        end else if (if_req) begin
          act = 1; act_d = 0; act_we = 0;
          last_addr = if_addr; last_we = 0;
          streak = 0;
        end
        if (act) begin
          g_cyc = c;
          lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 3))
                                            : int'($urandom_range(0, 2));
          act_to = (lat >= TIMEOUT);
          done_cyc = g_cyc + 2 + (act_to ? TIMEOUT - 1 : lat);
          act_rdata = {$urandom, $urandom};
        end
      end
      prev_if_done = e_if_done;
      prev_dm_done = e_dm_done;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
